// File: rtl/maze_tile_scanner.sv
// maze_tile_scanner: walks the maze cell RAM tile by tile and emits every
// pixel of each tile as an (x, y, colour) beat to the VGA plotter.
// Two request types: start (full-frame redraw from tile (0,0)) and
// start_one (redraw only tile (tile_x, tile_y)).
//
// Optional build macro: TILE_BORDER_EN -- when defined, pixels on the top
// row or left column of each tile take BORDER_COLOUR, drawing a grid.
//
// Pixel handshake: a beat transfers on a rising clk edge where pix_valid and
// pix_ready are both high. While pix_valid is high and pix_ready low, pix_x,
// pix_y, pix_colour and pix_valid hold steady; pix_valid never drops until
// the beat has transferred.
//
// dbg_state exposes the FSM encoding (0 IDLE, 1 FETCH, 2 WAIT, 3 DRAW, 4 DONE).
module maze_tile_scanner #(
  parameter int X_TILES    = 8,
  parameter int Y_TILES    = 6,
  parameter int TILE_SIZE  = 20,
  parameter int ROW_STRIDE = 16,
  parameter int ADDR_W     = 8,
  parameter int COORD_W    = 8,
  parameter int COL_W      = 3,
  parameter logic [COL_W-1:0] BORDER_COLOUR = '0
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               start_one,
  input  logic [3:0]         tile_x,
  input  logic [3:0]         tile_y,
  output logic               busy,
  output logic               done,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [COL_W-1:0]   mem_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [COL_W-1:0]   pix_colour,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [2:0]         dbg_state
);

  localparam int LW = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;
  localparam logic [LW-1:0] L_MAX  = LW'(TILE_SIZE - 1);
  localparam logic [3:0]    TX_MAX = 4'(X_TILES - 1);
  localparam logic [3:0]    TY_MAX = 4'(Y_TILES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, WAIT, DRAW, DONE} state_t;

  state_t             state, state_d;
  logic [3:0]         tx, ty;
  logic [LW-1:0]      lx, ly;
  logic               single;
  logic [COL_W-1:0]   col_q;
  logic [ADDR_W-1:0]  addr_q;

  logic               in_range, accept_full, accept_one;
  logic               xfer, lx_end, ly_end, last_px, frame_end, finish;
  logic               border_px;
  logic [ADDR_W-1:0]  addr_calc;
  logic [COORD_W-1:0] px_calc, py_calc;

  assign in_range  = ({28'd0, tile_x} < 32'(X_TILES)) && ({28'd0, tile_y} < 32'(Y_TILES));
  assign xfer      = (state == DRAW) && pix_ready;
  assign lx_end    = (lx == L_MAX);
  assign ly_end    = (ly == L_MAX);
  assign last_px   = lx_end && ly_end;
  assign frame_end = (tx == TX_MAX) && (ty == TY_MAX);
  assign finish    = single || frame_end;

  assign addr_calc = ADDR_W'(ty) * ADDR_W'(ROW_STRIDE) + ADDR_W'(tx);
  assign px_calc   = COORD_W'(tx) * COORD_W'(TILE_SIZE) + COORD_W'(lx);
  assign py_calc   = COORD_W'(ty) * COORD_W'(TILE_SIZE) + COORD_W'(ly);

`ifdef TILE_BORDER_EN
  assign border_px = (lx == '0) || (ly == '0);
`else
  assign border_px = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_d;
  end

  // Next-state logic and request acceptance.
  always_comb begin
    state_d     = state;
    accept_full = 1'b0;
    accept_one  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_full = 1'b1;
          state_d     = FETCH;
        end else if (start_one && in_range) begin
          accept_one = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH:   state_d = WAIT;
      WAIT:    state_d = DRAW;
      DRAW:    if (xfer && last_px) state_d = finish ? DONE : FETCH;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Tile/pixel counters, colour latch and held RAM address.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx     <= '0;
      ty     <= '0;
      lx     <= '0;
      ly     <= '0;
      single <= 1'b0;
      col_q  <= '0;
      addr_q <= '0;
    end else begin
      if (accept_full) begin
        tx     <= '0;
        ty     <= '0;
        single <= 1'b0;
      end else if (accept_one) begin
        tx     <= tile_x;
        ty     <= tile_y;
        single <= 1'b1;
      end
      if (state == FETCH) addr_q <= addr_calc;
      if (state == WAIT) begin
        col_q <= mem_data;
        lx    <= '0;
        ly    <= '0;
      end
      if (xfer) begin
        if (lx_end) begin
          lx <= '0;
          ly <= ly_end ? '0 : ly + LW'(1);
        end else begin
          lx <= lx + LW'(1);
        end
        if (last_px && !finish) begin
          if (tx == TX_MAX) begin
            tx <= '0;
            ty <= ty + 4'd1;
          end else begin
            tx <= tx + 4'd1;
          end
        end
      end
    end
  end

  // Outputs: RAM address is live in FETCH and held otherwise; pixel beats
  // are driven only in DRAW so idle/reset outputs read as zero.
  always_comb begin
    mem_addr   = (state == FETCH) ? addr_calc : addr_q;
    pix_valid  = (state == DRAW);
    pix_x      = pix_valid ? px_calc : '0;
    pix_y      = pix_valid ? py_calc : '0;
    pix_colour = pix_valid ? (border_px ? BORDER_COLOUR : col_q) : '0;
    busy       = (state == FETCH) || (state == WAIT) || (state == DRAW);
    done       = (state == DONE);
    dbg_state  = state;
  end

endmodule

// File: tb/tb_maze_tile_scanner.sv
// Bench for maze_tile_scanner: a synchronous cell RAM model, an expected-beat
// queue and an expected-address queue filled from the bench's own model, and
// a negedge monitor that pops and compares every transfer.
module tb_maze_tile_scanner;
  localparam int X  = 8;
  localparam int Y  = 6;
  localparam int TS = 20;
  localparam int RS = 16;
  localparam int AW = 8;
  localparam int CW = 8;
  localparam int KW = 3;
  localparam logic [KW-1:0] BORDER = 3'd7;
  localparam int FRAME_BEATS  = X * Y * TS * TS;
  localparam int FRAME_CYCLES = X * Y * (TS * TS + 2);
  localparam int TILE_CYCLES  = TS * TS + 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          start_one = 1'b0;
  logic [3:0]    tile_x = '0;
  logic [3:0]    tile_y = '0;
  logic          busy, done, pix_valid;
  logic [AW-1:0] mem_addr;
  logic [KW-1:0] mem_data = '0;
  logic [CW-1:0] pix_x, pix_y;
  logic [KW-1:0] pix_colour;
  logic          pix_ready = 1'b1;
  logic [2:0]    dbg_state;

  logic [KW-1:0]        ram [256];
  logic [2*CW+KW-1:0]   exp_q[$];
  logic [AW-1:0]        addr_q[$];
  int  tests = 0;
  int  fails = 0;
  int  beat_cnt = 0;
  int  done_cnt = 0;
  bit  rand_mode = 1'b0;
  bit  stall_prev = 1'b0;
  logic [2*CW+KW:0] held = '0;

  maze_tile_scanner #(
    .X_TILES(X), .Y_TILES(Y), .TILE_SIZE(TS), .ROW_STRIDE(RS),
    .ADDR_W(AW), .COORD_W(CW), .COL_W(KW), .BORDER_COLOUR(BORDER)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .start_one(start_one),
    .tile_x(tile_x), .tile_y(tile_y), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_data(mem_data), .pix_x(pix_x), .pix_y(pix_y),
    .pix_colour(pix_colour), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Cell RAM with one-cycle synchronous read.
  always @(posedge clk) mem_data <= ram[mem_addr];

  // Monitor: stall stability, beat scoreboard, address scoreboard, done count.
  always @(negedge clk) begin
    if (resetn) begin
      if (stall_prev) begin
        tests++;
        if ({pix_x, pix_y, pix_colour, pix_valid} !== held) begin
          fails++;
          $display("FAIL stall_hold: got %h required %h", {pix_x, pix_y, pix_colour, pix_valid}, held);
        end
      end
      if (pix_valid && pix_ready) begin
        beat_cnt++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL extra_beat: got (%0d,%0d) col %0d, required no beat", pix_x, pix_y, pix_colour);
        end else begin
          logic [2*CW+KW-1:0] e;
          e = exp_q.pop_front();
          if ({pix_x, pix_y, pix_colour} !== e) begin
            fails++;
            $display("FAIL beat: got (%0d,%0d) col %0d required (%0d,%0d) col %0d",
                     pix_x, pix_y, pix_colour, e[2*CW+KW-1:CW+KW], e[CW+KW-1:KW], e[KW-1:0]);
          end
        end
      end
      if (dbg_state == 3'd1) begin
        tests++;
        if (addr_q.size() == 0) begin
          fails++;
          $display("FAIL mem_addr: got %0d required no fetch", mem_addr);
        end else begin
          logic [AW-1:0] a;
          a = addr_q.pop_front();
          if (mem_addr !== a) begin
            fails++;
            $display("FAIL mem_addr: got %0d required %0d", mem_addr, a);
          end
        end
      end
      if (done) done_cnt++;
    end
    stall_prev = resetn && pix_valid && !pix_ready;
    held = {pix_x, pix_y, pix_colour, pix_valid};
  end

  // Driver: advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_mode) pix_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_tile(input int tx, input int ty);
    logic [KW-1:0] c;
    logic [CW-1:0] px, py;
    addr_q.push_back(AW'(ty * RS + tx));
    for (int ly = 0; ly < TS; ly++) begin
      for (int lx = 0; lx < TS; lx++) begin
        c = ram[ty * RS + tx];
`ifdef TILE_BORDER_EN
        if (lx == 0 || ly == 0) c = BORDER;
`endif
        px = CW'(tx * TS + lx);
        py = CW'(ty * TS + ly);
        exp_q.push_back({px, py, c});
      end
    end
  endtask

  task automatic push_frame();
    for (int ty = 0; ty < Y; ty++)
      for (int tx = 0; tx < X; tx++)
        push_tile(tx, ty);
  endtask

  // Wait for done after an accept; returns edges counted since accept.
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (!done && cycles < budget) begin
      step();
      cycles++;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step();
    step();
    tests++;
    if ({busy, done, pix_valid, mem_addr, pix_x, pix_y, pix_colour, dbg_state} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0",
               {busy, done, pix_valid, mem_addr, pix_x, pix_y, pix_colour, dbg_state});
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_full_frame();
    int cyc, b0, d0;
    b0 = beat_cnt;
    d0 = done_cnt;
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (busy !== 1'b1 || mem_addr !== 8'd0 || pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_accept: got busy %b addr %0d valid %b required 1 0 0", busy, mem_addr, pix_valid);
    end
    wait_done(FRAME_CYCLES + 100, cyc);
    tests++;
    if (cyc != FRAME_CYCLES) begin
      fails++;
      $display("FAIL full_latency: got %0d required %0d", cyc, FRAME_CYCLES);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL full_done_busy: got %b required 0", busy);
    end
    step();
    tests++;
    if (done !== 1'b0 || done_cnt - d0 != 1) begin
      fails++;
      $display("FAIL full_done_pulse: got done %b count %0d required 0 1", done, done_cnt - d0);
    end
    tests++;
    if (beat_cnt - b0 != FRAME_BEATS || exp_q.size() != 0 || addr_q.size() != 0) begin
      fails++;
      $display("FAIL full_beats: got %0d left %0d/%0d required %0d 0/0",
               beat_cnt - b0, exp_q.size(), addr_q.size(), FRAME_BEATS);
    end
  endtask

  task automatic test_single(input int tx, input int ty);
    int cyc, b0;
    b0 = beat_cnt;
    push_tile(tx, ty);
    tile_x = 4'(tx);
    tile_y = 4'(ty);
    start_one = 1'b1;
    step();
    start_one = 1'b0;
    tests++;
    if (busy !== 1'b1 || mem_addr !== AW'(ty * RS + tx)) begin
      fails++;
      $display("FAIL single_accept: got busy %b addr %0d required 1 %0d", busy, mem_addr, ty * RS + tx);
    end
    step();
    tests++;
    if (pix_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_wait_valid: got %b required 0", pix_valid);
    end
    step();
    tests++;
    if (pix_valid !== 1'b1) begin
      fails++;
      $display("FAIL single_first_valid: got %b required 1", pix_valid);
    end
    wait_done(TILE_CYCLES + 50, cyc);
    cyc += 2;
    tests++;
    if (cyc != TILE_CYCLES || beat_cnt - b0 != TS * TS) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles %0d beats required %0d %0d",
               cyc, beat_cnt - b0, TILE_CYCLES, TS * TS);
    end
    // A request in the done cycle must be ignored.
    start = 1'b1;
    step();
    start = 1'b0;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL done_cycle_request: got busy %b done %b required 0 0", busy, done);
    end
    step();
  endtask

  task automatic test_ignored();
    logic [3:0] bad_x[2];
    logic [3:0] bad_y[2];
    int b0;
    bad_x[0] = 4'd8; bad_y[0] = 4'd0;
    bad_x[1] = 4'd0; bad_y[1] = 4'd6;
    b0 = beat_cnt;
    for (int k = 0; k < 2; k++) begin
      tile_x = bad_x[k];
      tile_y = bad_y[k];
      start_one = 1'b1;
      step();
      start_one = 1'b0;
      for (int c = 0; c < 5; c++) begin
        tests++;
        if (busy !== 1'b0 || pix_valid !== 1'b0) begin
          fails++;
          $display("FAIL ignored_req: got busy %b valid %b required 0 0", busy, pix_valid);
        end
        step();
      end
    end
    tests++;
    if (beat_cnt != b0) begin
      fails++;
      $display("FAIL ignored_beats: got %0d required %0d", beat_cnt - b0, 0);
    end
  endtask

  task automatic test_priority_reset();
    int n, d0;
    d0 = done_cnt;
    push_frame();
    tile_x = 4'd3;
    tile_y = 4'd2;
    start = 1'b1;
    start_one = 1'b1;
    step();
    start = 1'b0;
    start_one = 1'b0;
    tests++;
    if (busy !== 1'b1 || mem_addr !== 8'd0) begin
      fails++;
      $display("FAIL priority_addr: got busy %b addr %0d required 1 0", busy, mem_addr);
    end
    n = 0;
    while (exp_q.size() > FRAME_BEATS - (10 * TS * TS + 200) && n < 6000) begin
      step();
      n++;
    end
    resetn = 1'b0;
    step();
    tests++;
    if ({busy, done, pix_valid, mem_addr, pix_x, pix_y, pix_colour, dbg_state} !== '0) begin
      fails++;
      $display("FAIL midframe_reset: got %h required 0",
               {busy, done, pix_valid, mem_addr, pix_x, pix_y, pix_colour, dbg_state});
    end
    step();
    resetn = 1'b1;
    exp_q.delete();
    addr_q.delete();
    step();
    step();
    tests++;
    if (done_cnt != d0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_done: got %0d dones busy %b required 0 0", done_cnt - d0, busy);
    end
  endtask

  task automatic test_random_ready();
    int cyc, b0, d0;
    b0 = beat_cnt;
    d0 = done_cnt;
    push_frame();
    rand_mode = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(4 * FRAME_CYCLES, cyc);
    rand_mode = 1'b0;
    pix_ready = 1'b1;
    step();
    tests++;
    if (cyc < FRAME_CYCLES || beat_cnt - b0 != FRAME_BEATS || done_cnt - d0 != 1 ||
        exp_q.size() != 0 || addr_q.size() != 0) begin
      fails++;
      $display("FAIL random_frame: got %0d cycles %0d beats %0d dones left %0d required >=%0d %0d 1 0",
               cyc, beat_cnt - b0, done_cnt - d0, exp_q.size(), FRAME_CYCLES, FRAME_BEATS);
    end
  endtask

  initial begin
    for (int a = 0; a < 256; a++) ram[a] = KW'(((a % RS) + (a / RS)) & 7);
    test_reset();
    test_full_frame();
    test_single(3, 2);
    test_single(1, 1);
    test_ignored();
    test_priority_reset();
    test_random_ready();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
